// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word widths, major opcodes and sequencer states.
package pdp8_pkg;

  localparam int unsigned PDP8_AW = 12;
  localparam int unsigned PDP8_DW = 12;

  // Major opcodes, IR[11:9]
  localparam logic [2:0] OPC_AND = 3'o0;
  localparam logic [2:0] OPC_TAD = 3'o1;
  localparam logic [2:0] OPC_ISZ = 3'o2;
  localparam logic [2:0] OPC_DCA = 3'o3;
  localparam logic [2:0] OPC_JMS = 3'o4;
  localparam logic [2:0] OPC_JMP = 3'o5;
  localparam logic [2:0] OPC_IOT = 3'o6;
  localparam logic [2:0] OPC_OPR = 3'o7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INCR,
    S_EXEC,
    S_JMS_WR,
    S_BRANCH
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/branch controller: owns the program counter's control strobes and
// issues one instruction fetch at a time (no prefetch).
module pc_sequencer #(
  parameter int unsigned AW     = pdp8_pkg::PDP8_AW,
  parameter int unsigned DW     = pdp8_pkg::PDP8_DW,
  parameter logic [2:0]  OP_JMS = pdp8_pkg::OPC_JMS,
  parameter logic [2:0]  OP_JMP = pdp8_pkg::OPC_JMP
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          run,
  input  logic [AW-1:0] pc,
  output logic          pc_clr,
  output logic          pc_ld,
  output logic [AW-1:0] pc_in,
  output logic          pc_inc,
  output logic          pc_latch,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir,
  output logic          ir_valid,
  input  logic          exec_done,
  input  logic          exec_skip,
  input  logic [AW-1:0] exec_ea,
  output logic          running
);
  import pdp8_pkg::*;

  seq_state_e    state, state_next;
  logic          fetch_first;
  logic          clr_q;
  logic [AW-1:0] ea_q;
  logic [AW-1:0] target_q;
  logic [DW-1:0] ret_q;
  logic [2:0]    op;
  logic          is_jmp, is_jms;

  assign op     = ir[DW-1 -: 3];
  assign is_jmp = (op == OP_JMP);
  assign is_jms = (op == OP_JMS);

  // State register; clear returns to IDLE from anywhere, dropping any request.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      fetch_first <= 1'b0;
    end else begin
      state       <= state_next;
      fetch_first <= (state_next == S_FETCH) && (state != S_FETCH);
    end
  end

  // Clear-release detector: PC_CLR fires in the first cycle after CLR drops.
  always_ff @(posedge clk) begin
    clr_q <= clr;
  end

  // Instruction register and branch/return bookkeeping.
  always_ff @(posedge clk) begin
    if (clr) begin
      ir       <= '0;
      ea_q     <= '0;
      target_q <= '0;
      ret_q    <= '0;
    end else begin
      if (state == S_FETCH && mem_ack) begin
        ir <= mem_rdata;
      end
      if (state == S_EXEC && exec_done) begin
        ea_q     <= exec_ea;
        target_q <= exec_ea;
        ret_q    <= DW'(pc);
      end
      if (state == S_JMS_WR && mem_ack) begin
        target_q <= ea_q + AW'(1);
      end
    end
  end

  // Next-state decode; RUN is only consulted at instruction boundaries.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (run) state_next = S_FETCH;
      S_FETCH:  if (mem_ack) state_next = S_INCR;
      S_INCR:   state_next = S_EXEC;
      S_EXEC: begin
        if (exec_done) begin
          if (is_jmp)      state_next = S_BRANCH;
          else if (is_jms) state_next = S_JMS_WR;
          else if (run)    state_next = S_FETCH;
          else             state_next = S_IDLE;
        end
      end
      S_JMS_WR: if (mem_ack) state_next = S_BRANCH;
      S_BRANCH: state_next = run ? S_FETCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode; an asserted clear masks everything in its own cycle.
  always_comb begin
    pc_clr    = 1'b0;
    pc_ld     = 1'b0;
    pc_in     = '0;
    pc_inc    = 1'b0;
    pc_latch  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    ir_valid  = 1'b0;
    running   = 1'b0;
    if (!clr) begin
      pc_clr  = clr_q;
      running = (state != S_IDLE);
      unique case (state)
        S_FETCH: begin
          mem_rd   = 1'b1;
          mem_addr = pc;
          pc_latch = fetch_first;
        end
        S_INCR:  pc_inc = 1'b1;
        S_EXEC: begin
          ir_valid = 1'b1;
          pc_inc   = exec_done && exec_skip && !is_jmp && !is_jms;
        end
        S_JMS_WR: begin
          mem_wr    = 1'b1;
          mem_addr  = ea_q;
          mem_wdata = ret_q;
        end
        S_BRANCH: begin
          pc_ld = 1'b1;
          pc_in = target_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: program counter, memory and execute-unit models
// around the DUT, directed scenarios plus randomized programs checked
// against an instruction-level reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        clr, run;
  logic [11:0] pc;
  logic        pc_clr, pc_ld, pc_inc, pc_latch;
  logic [11:0] pc_in, mem_addr, mem_wdata, mem_rdata, ir, exec_ea;
  logic        mem_rd, mem_wr, mem_ack, ir_valid, exec_done, exec_skip, running;

  pc_sequencer #(.AW(12), .DW(12), .OP_JMS(3'o4), .OP_JMP(3'o5)) dut (
    .clk(clk), .clr(clr), .run(run), .pc(pc),
    .pc_clr(pc_clr), .pc_ld(pc_ld), .pc_in(pc_in), .pc_inc(pc_inc), .pc_latch(pc_latch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .exec_skip(exec_skip), .exec_ea(exec_ea), .running(running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] mem     [4096];
  logic [11:0] ref_mem [4096];
  bit          skip_tab[4096];

  int   lat_mode    = 0;  // memory: 0 = immediate, 1 = random 0..3, 2 = very slow
  int   ex_lat_mode = 0;  // execute: 0 = immediate, 1 = random 0..3, 2 = fixed 4
  bit   noise       = 1'b0;
  logic pc_force_en = 1'b0;
  logic [11:0] pc_force_val = '0;
  logic inject_ack  = 1'b0;

  // Monitor logs (only the monitor writes these)
  logic [11:0] fetch_q[$];
  logic [11:0] latch_q[$];
  logic [23:0] wr_q[$];
  int          ftime_q[$];
  int          n_clr = 0, n_ld = 0, n_inc = 0, n_mutex = 0, cyc = 0;
  logic [11:0] last_ld = '0, last_fetch = '0;

  // Bases captured at the start of each scenario
  int fb, lb, wb, b_clr, b_ld, b_inc, b_mutex;

  logic [11:0] exp_f[$];
  logic [23:0] exp_w[$];

  function automatic logic [11:0] ea_of(input logic [11:0] ins, input logic [11:0] addr);
    return ins[7] ? {addr[11:7], ins[6:0]} : {5'b0, ins[6:0]};
  endfunction

  function automatic int pick_lat(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return $urandom_range(0, 3);
    return 50;
  endfunction

  // Memory responder
  initial begin
    int wcnt, lat;
    wcnt = 0; lat = 0; mem_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 12'($urandom);
      if (inject_ack) begin
        mem_ack = 1'b1;
      end else if (mem_rd || mem_wr) begin
        if (wcnt == 0) lat = pick_lat(lat_mode);
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_rd) mem_rdata = mem[mem_addr];
          else        mem[mem_addr] = mem_wdata;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (noise && $urandom_range(0, 7) == 0) mem_ack = 1'b1;
      end
    end
  end

  // Execute-unit responder
  initial begin
    int wcnt, lat;
    wcnt = 0; lat = 0; exec_done = 1'b0; exec_skip = 1'b0; exec_ea = '0;
    forever begin
      @(negedge clk);
      exec_done = 1'b0;
      exec_skip = 1'($urandom);
      exec_ea   = 12'($urandom);
      if (ir_valid) begin
        if (wcnt == 0) lat = (ex_lat_mode == 2) ? 4 : pick_lat(ex_lat_mode);
        if (wcnt >= lat) begin
          exec_done = 1'b1;
          exec_ea   = ea_of(ir, last_fetch);
          if (ir[11:9] != 3'o4 && ir[11:9] != 3'o5) exec_skip = skip_tab[last_fetch];
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        if (noise && $urandom_range(0, 3) == 0) exec_done = 1'b1;
      end
    end
  end

  // Monitor and program-counter model
  initial begin
    logic [11:0] pc_nxt;
    pc = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (mem_rd && mem_ack) begin
        fetch_q.push_back(mem_addr);
        ftime_q.push_back(cyc);
        last_fetch = mem_addr;
      end
      if (mem_wr && mem_ack) wr_q.push_back({mem_addr, mem_wdata});
      if (pc_latch) latch_q.push_back(pc);
      if (pc_clr) n_clr++;
      if (pc_ld) begin n_ld++; last_ld = pc_in; end
      if (pc_inc) n_inc++;
      if (int'(pc_clr) + int'(pc_ld) + int'(pc_inc) > 1) n_mutex++;
      if (pc_force_en)  pc_nxt = pc_force_val;
      else if (pc_clr)  pc_nxt = '0;
      else if (pc_ld)   pc_nxt = pc_in;
      else if (pc_inc)  pc_nxt = pc + 12'd1;
      else              pc_nxt = pc;
      @(posedge clk);
      pc <= pc_nxt;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    fb = fetch_q.size(); lb = latch_q.size(); wb = wr_q.size();
    b_clr = n_clr; b_ld = n_ld; b_inc = n_inc; b_mutex = n_mutex;
  endtask

  task automatic start_at(input logic [11:0] addr);
    tick();
    pc_force_val = addr;
    pc_force_en  = 1'b1;
    tick();
    pc_force_en  = 1'b0;
    run          = 1'b1;
  endtask

  // Let n instructions be fetched, drop RUN, then wait for IDLE.
  task automatic run_n(input int n, output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (k < 4000 && (fetch_q.size() - fb) < n) begin tick(); k++; end
    run = 1'b0;
    k = 0;
    while (k < 200) begin
      tick(); #2;
      if (!running) begin ok = 1'b1; break; end
      k++;
    end
  endtask

  task automatic test_nop();
    bit ok;
    mem[12'o0200] = 12'o7000; mem[12'o0201] = 12'o7000;
    skip_tab[12'o0200] = 1'b0; skip_tab[12'o0201] = 1'b0;
    lat_mode = 0; ex_lat_mode = 0;
    snap();
    start_at(12'o0200);
    run_n(2, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL nop_timeout: running did not drop"); end
    n_tests++; if (fetch_q[fb] !== 12'o0200) begin n_fail++; $display("FAIL nop_fetch0: got %o want 0200", fetch_q[fb]); end
    n_tests++; if (fetch_q[fb+1] !== 12'o0201) begin n_fail++; $display("FAIL nop_fetch1: got %o want 0201", fetch_q[fb+1]); end
    n_tests++; if (ir !== 12'o7000) begin n_fail++; $display("FAIL nop_ir: got %o want 7000", ir); end
    n_tests++; if (n_inc - b_inc != 2) begin n_fail++; $display("FAIL nop_inc: got %0d want 2", n_inc - b_inc); end
    n_tests++; if (pc !== 12'o0202) begin n_fail++; $display("FAIL nop_pc: got %o want 0202", pc); end
    n_tests++; if (latch_q.size() - lb != 2 || latch_q[lb] !== 12'o0200) begin
      n_fail++; $display("FAIL nop_latch: got %0d latches first %o want 2 first 0200", latch_q.size() - lb, latch_q[lb]);
    end
  endtask

  task automatic test_skip();
    bit ok;
    mem[12'o0201] = 12'o7450; skip_tab[12'o0201] = 1'b1;
    mem[12'o0203] = 12'o7000; skip_tab[12'o0203] = 1'b0;
    snap();
    start_at(12'o0201);
    run_n(2, ok);
    n_tests++; if (!ok || fetch_q[fb+1] !== 12'o0203) begin n_fail++; $display("FAIL skip_fetch: got %o want 0203", fetch_q[fb+1]); end
    n_tests++; if (n_inc - b_inc != 3) begin n_fail++; $display("FAIL skip_inc: got %0d want 3", n_inc - b_inc); end
    n_tests++; if (pc !== 12'o0204) begin n_fail++; $display("FAIL skip_pc: got %o want 0204", pc); end
  endtask

  task automatic test_jmp();
    bit ok;
    mem[12'o0200] = 12'o5377; skip_tab[12'o0200] = 1'b1;
    mem[12'o0377] = 12'o7000; skip_tab[12'o0377] = 1'b0;
    snap();
    start_at(12'o0200);
    run_n(2, ok);
    n_tests++; if (!ok || fetch_q[fb+1] !== 12'o0377) begin n_fail++; $display("FAIL jmp_fetch: got %o want 0377", fetch_q[fb+1]); end
    n_tests++; if (n_ld - b_ld != 1 || last_ld !== 12'o0377) begin n_fail++; $display("FAIL jmp_ld: got %0d loads value %o want 1 load 0377", n_ld - b_ld, last_ld); end
    n_tests++; if (n_inc - b_inc != 2) begin n_fail++; $display("FAIL jmp_inc: got %0d want 2", n_inc - b_inc); end
    n_tests++; if (pc !== 12'o0400) begin n_fail++; $display("FAIL jmp_pc: got %o want 0400", pc); end
  endtask

  task automatic test_jms();
    bit ok;
    mem[12'o0300] = 12'o4350; skip_tab[12'o0300] = 1'b1;
    mem[12'o0350] = 12'o0000;
    mem[12'o0351] = 12'o7000; skip_tab[12'o0351] = 1'b0;
    snap();
    start_at(12'o0300);
    run_n(2, ok);
    n_tests++; if (!ok || wr_q.size() - wb != 1 || wr_q[wb] !== {12'o0350, 12'o0301}) begin
      n_fail++; $display("FAIL jms_write: got %0d writes first %o want one write 0350:0301", wr_q.size() - wb, wr_q[wb]);
    end
    n_tests++; if (mem[12'o0350] !== 12'o0301) begin n_fail++; $display("FAIL jms_mem: got %o want 0301", mem[12'o0350]); end
    n_tests++; if (last_ld !== 12'o0351) begin n_fail++; $display("FAIL jms_ld: got %o want 0351", last_ld); end
    n_tests++; if (fetch_q[fb+1] !== 12'o0351) begin n_fail++; $display("FAIL jms_fetch: got %o want 0351", fetch_q[fb+1]); end
    n_tests++; if (pc !== 12'o0352) begin n_fail++; $display("FAIL jms_pc: got %o want 0352", pc); end
  endtask

  task automatic test_wrap_stop();
    bit ok;
    int k;
    mem[12'o7777] = 12'o7000; skip_tab[12'o7777] = 1'b0;
    snap();
    start_at(12'o7777);
    run_n(1, ok);
    n_tests++; if (!ok || pc !== 12'o0000) begin n_fail++; $display("FAIL wrap_pc: got %o want 0000", pc); end
    // RUN drops while the execute unit is still busy
    mem[12'o0200] = 12'o7000; skip_tab[12'o0200] = 1'b0;
    ex_lat_mode = 2;
    snap();
    start_at(12'o0200);
    k = 0;
    while (k < 200) begin tick(); #2; if (ir_valid) break; k++; end
    run = 1'b0;
    repeat (2) tick();
    n_tests++; if (running !== 1'b1) begin n_fail++; $display("FAIL stop_midinstr: running got %b want 1", running); end
    k = 0;
    while (k < 200) begin tick(); #2; if (!running) break; k++; end
    n_tests++; if (running !== 1'b0 || fetch_q.size() - fb != 1 || pc !== 12'o0201) begin
      n_fail++; $display("FAIL stop_idle: running %b fetches %0d pc %o want 0 1 0201", running, fetch_q.size() - fb, pc);
    end
    ex_lat_mode = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int unsigned a = 12'o0100; a < 12'o0106; a++) begin mem[a] = 12'o7000; skip_tab[a] = 1'b0; end
    lat_mode = 0; ex_lat_mode = 0;
    snap();
    start_at(12'o0100);
    run_n(4, ok);
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (ftime_q[fb+i] - ftime_q[fb+i-1] != 3) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: got %0d cycles want 3", i, ftime_q[fb+i] - ftime_q[fb+i-1]);
      end
    end
  endtask

  task automatic test_reset();
    snap();
    lat_mode = 2;
    start_at(12'o0200);
    repeat (3) tick();
    #2;
    n_tests++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL reset_prereq: mem_rd got %b want 1", mem_rd); end
    tick(); clr = 1'b1; run = 1'b0; #2;
    n_tests++; if ({mem_rd, mem_wr, running, pc_clr, pc_inc, pc_ld, pc_latch, ir_valid} !== 8'h00) begin
      n_fail++; $display("FAIL reset_during: outputs got %b want 00000000", {mem_rd, mem_wr, running, pc_clr, pc_inc, pc_ld, pc_latch, ir_valid});
    end
    tick(); clr = 1'b0; #2;
    n_tests++; if (pc_clr !== 1'b1) begin n_fail++; $display("FAIL reset_pcclr: got %b want 1", pc_clr); end
    n_tests++; if ({running, mem_rd, ir_valid} !== 3'b000 || ir !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++; $display("FAIL reset_state: run/rd/valid %b ir %o addr %o wdata %o want all 0", {running, mem_rd, ir_valid}, ir, mem_addr, mem_wdata);
    end
    inject_ack = 1'b1;
    tick(); inject_ack = 1'b0; #2;
    n_tests++; if (pc_clr !== 1'b0) begin n_fail++; $display("FAIL reset_pcclr_once: got %b want 0", pc_clr); end
    tick(); #2;
    n_tests++; if (running !== 1'b0 || ir !== '0) begin n_fail++; $display("FAIL reset_late_ack: running %b ir %o want 0 0000", running, ir); end
    repeat (3) tick();
    n_tests++; if (n_clr - b_clr != 1 || pc !== '0) begin n_fail++; $display("FAIL reset_pulses: got %0d pulses pc %o want 1 0000", n_clr - b_clr, pc); end
    lat_mode = 0;
  endtask

  task automatic model_run(input logic [11:0] start, input int n, output logic [11:0] fin);
    logic [11:0] a, ins, ea;
    exp_f.delete();
    exp_w.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_f.push_back(a);
      ins = ref_mem[a];
      ea  = ea_of(ins, a);
      case (ins[11:9])
        3'o5: a = ea;
        3'o4: begin
          exp_w.push_back({ea, a + 12'd1});
          ref_mem[ea] = a + 12'd1;
          a = ea + 12'd1;
        end
        default: a = a + 12'd1 + (skip_tab[a] ? 12'd1 : 12'd0);
      endcase
    end
    fin = a;
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    logic [11:0] start, fin;
    for (int r = 0; r < 4; r++) begin
      for (int unsigned a = 0; a < 4096; a++) begin
        mem[a] = 12'($urandom);
        skip_tab[a] = 1'($urandom);
      end
      ref_mem = mem;
      start = 12'($urandom);
      model_run(start, 30, fin);
      lat_mode = 1; ex_lat_mode = 1; noise = 1'b1;
      snap();
      start_at(start);
      run_n(30, ok);
      noise = 1'b0;
      n_tests++; if (!ok || fetch_q.size() - fb != 30) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d fetches want 30", r, fetch_q.size() - fb); end
      bad = -1;
      for (int i = 0; i < 30; i++) if (bad < 0 && fetch_q[fb+i] !== exp_f[i]) bad = i;
      n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL rand_fetch[%0d]: instr %0d got %o want %o", r, bad, fetch_q[fb+bad], exp_f[bad]); end
      bad = -1;
      for (int i = 0; i < 30; i++) if (bad < 0 && latch_q[lb+i] !== exp_f[i]) bad = i;
      n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL rand_latch[%0d]: instr %0d got %o want %o", r, bad, latch_q[lb+bad], exp_f[bad]); end
      bad = (wr_q.size() - wb != exp_w.size()) ? 0 : -1;
      for (int i = 0; i < exp_w.size(); i++) if (bad < 0 && wr_q[wb+i] !== exp_w[i]) bad = i;
      n_tests++; if (bad >= 0) begin n_fail++; $display("FAIL rand_write[%0d]: %0d writes want %0d, entry %0d got %o want %o", r, wr_q.size() - wb, exp_w.size(), bad, wr_q[wb+bad], exp_w[bad]); end
      n_tests++; if (pc !== fin) begin n_fail++; $display("FAIL rand_pc[%0d]: got %o want %o", r, pc, fin); end
    end
    lat_mode = 0; ex_lat_mode = 0;
    n_tests++; if (n_mutex != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles want 0", n_mutex); end
  endtask

  initial begin
    clr = 1'b1;
    run = 1'b0;
    for (int unsigned a = 0; a < 4096; a++) begin mem[a] = 12'o7000; skip_tab[a] = 1'b0; end
    repeat (3) tick();
    clr = 1'b0;
    repeat (2) tick();
    test_nop();
    test_skip();
    test_jmp();
    test_jms();
    test_reset();
    test_wrap_stop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
